// File: rtl/ns_traffic_gen_chk.sv
// Counting message source and sequence-checking sink for
// network bring-up; both channels use a four-phase req/ack handshake.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module ns_traffic_gen_chk #(
  parameter int SRC_ID    = 0,
  parameter int MIN_ADDR  = 1,
  parameter int MAX_ADDR  = 1,
  parameter int ASZ       = `NS_ADDRESS_SIZE,
  parameter int DSZ       = `NS_DATA_SIZE,
  parameter int RSZ       = `NS_REDUN_SIZE,
  parameter int NUM_SRC   = 2,
  parameter int CNT_MAX   = 15,
  parameter int MSG_LIMIT = 0,
  parameter int CSZ       = 16
) (
  input  logic               i_clk,
  input  logic               reset,
  input  logic               i_enable,
  output logic [ASZ-1:0]     o0_src,
  output logic [ASZ-1:0]     o0_dst,
  output logic [DSZ-1:0]     o0_dat,
  output logic [RSZ-1:0]     o0_red,
  output logic               o0_req,
  input  logic               o0_ack,
  input  logic [ASZ-1:0]     i0_src,
  input  logic [ASZ-1:0]     i0_dst,
  input  logic [DSZ-1:0]     i0_dat,
  input  logic [RSZ-1:0]     i0_red,
  input  logic               i0_req,
  output logic               i0_ack,
  output logic [NUM_SRC-1:0] o_err_red,
  output logic [NUM_SRC-1:0] o_err_seq,
  output logic               o_err_rng,
  output logic               o_err_src,
  output logic [DSZ-1:0]     o_fst_exp,
  output logic [DSZ-1:0]     o_fst_got,
  output logic [CSZ-1:0]     o_sent_cnt,
  output logic [CSZ-1:0]     o_recv_cnt,
  output logic               o_done
);

  localparam int VW = 2 * ASZ + DSZ;

  // Redundancy: XOR-fold of {src,dst,dat} into RSZ bits.
  function automatic logic [RSZ-1:0] calc_redun(
    input logic [ASZ-1:0] s,
    input logic [ASZ-1:0] d,
    input logic [DSZ-1:0] x
  );
    logic [VW-1:0]  v;
    logic [RSZ-1:0] r;
    v = {s, d, x};
    r = '0;
    for (int i = 0; i < VW; i++) r[i % RSZ] ^= v[i];
    return r;
  endfunction

  function automatic logic [DSZ-1:0] nxt(input logic [DSZ-1:0] x);
    return (x == DSZ'(CNT_MAX)) ? '0 : x + DSZ'(1);
  endfunction

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RED, S_REQ, S_RLS
  } src_st_t;

  typedef enum logic [1:0] {
    K_WAIT, K_CHK, K_ACK, K_HOLD
  } snk_st_t;

  src_st_t          r_sst;
  logic [DSZ-1:0]   r_cnt;
  logic [ASZ-1:0]   r_dst;
  logic [DSZ-1:0]   r_dat;
  logic [RSZ-1:0]   r_red;
  logic             r_req;
  logic [CSZ-1:0]   r_sent;
  logic             r_done;

  snk_st_t          r_kst;
  logic [ASZ-1:0]   r_m_src;
  logic [ASZ-1:0]   r_m_dst;
  logic [DSZ-1:0]   r_m_dat;
  logic [RSZ-1:0]   r_m_red;
  logic             r_ack;
  logic [CSZ-1:0]   r_recv;
  logic [NUM_SRC-1:0] r_seen;
  logic [DSZ-1:0]   r_last [NUM_SRC];
  logic [NUM_SRC-1:0] r_err_red;
  logic [NUM_SRC-1:0] r_err_seq;
  logic             r_err_rng;
  logic             r_err_src;
  logic             r_fst_vld;
  logic [DSZ-1:0]   r_fst_exp;
  logic [DSZ-1:0]   r_fst_got;

  logic [ASZ-1:0]   w_src;
  assign w_src = ASZ'(SRC_ID);

  assign o0_src     = w_src;
  assign o0_dst     = r_dst;
  assign o0_dat     = r_dat;
  assign o0_red     = r_red;
  assign o0_req     = r_req;
  assign o_sent_cnt = r_sent;
  assign o_done     = r_done;
  assign i0_ack     = r_ack;
  assign o_recv_cnt = r_recv;
  assign o_err_red  = r_err_red;
  assign o_err_seq  = r_err_seq;
  assign o_err_rng  = r_err_rng;
  assign o_err_src  = r_err_src;
  assign o_fst_exp  = r_fst_exp;
  assign o_fst_got  = r_fst_got;

  // Source FSM: load counter, stamp redundancy, then handshake.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_sst  <= S_IDLE;
      r_cnt  <= '0;
      r_dst  <= ASZ'(MIN_ADDR);
      r_dat  <= '0;
      r_red  <= '0;
      r_req  <= 1'b0;
      r_sent <= '0;
      r_done <= 1'b0;
    end else begin
      unique case (r_sst)
        S_IDLE: if (i_enable && !r_done && !o0_ack) r_sst <= S_LOAD;
        S_LOAD: begin
          r_dat <= r_cnt;
          r_cnt <= nxt(r_cnt);
          r_sst <= S_RED;
        end
        S_RED: begin
          r_red <= calc_redun(w_src, r_dst, r_dat);
          r_req <= 1'b1;
          r_sst <= S_REQ;
        end
        S_REQ: if (o0_ack) begin
          r_req  <= 1'b0;
          r_dst  <= (r_dst == ASZ'(MAX_ADDR)) ?
                    ASZ'(MIN_ADDR) : r_dst + ASZ'(1);
          r_sent <= r_sent + CSZ'(1);
          if (MSG_LIMIT != 0 &&
              (r_sent + CSZ'(1)) == CSZ'(MSG_LIMIT))
            r_done <= 1'b1;
          r_sst  <= S_RLS;
        end
        S_RLS: if (!o0_ack) r_sst <= S_IDLE;
        default: r_sst <= S_IDLE;
      endcase
    end
  end

  // Sink FSM: latch, check one cycle, then ack and wait for release.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_kst     <= K_WAIT;
      r_m_src   <= '0;
      r_m_dst   <= '0;
      r_m_dat   <= '0;
      r_m_red   <= '0;
      r_ack     <= 1'b0;
      r_recv    <= '0;
      r_seen    <= '0;
      r_err_red <= '0;
      r_err_seq <= '0;
      r_err_rng <= 1'b0;
      r_err_src <= 1'b0;
      r_fst_vld <= 1'b0;
      r_fst_exp <= '0;
      r_fst_got <= '0;
      for (int s = 0; s < NUM_SRC; s++) r_last[s] <= '0;
    end else begin
      unique case (r_kst)
        K_WAIT: if (i0_req && !r_ack) begin
          r_m_src <= i0_src;
          r_m_dst <= i0_dst;
          r_m_dat <= i0_dat;
          r_m_red <= i0_red;
          r_kst   <= K_CHK;
        end
        K_CHK: begin
          if (r_m_src >= ASZ'(NUM_SRC)) begin
            r_err_src <= 1'b1;
          end else begin
            if (r_m_dat > DSZ'(CNT_MAX)) r_err_rng <= 1'b1;
            for (int s = 0; s < NUM_SRC; s++) begin
              if (r_m_src == ASZ'(s)) begin
                if (r_m_red !=
                    calc_redun(r_m_src, r_m_dst, r_m_dat)) begin
                  r_err_red[s] <= 1'b1;
                end else begin
                  if (r_seen[s] && r_m_dat != nxt(r_last[s])) begin
                    r_err_seq[s] <= 1'b1;
                    if (!r_fst_vld) begin
                      r_fst_vld <= 1'b1;
                      r_fst_exp <= nxt(r_last[s]);
                      r_fst_got <= r_m_dat;
                    end
                  end
                  r_last[s] <= r_m_dat;
                  r_seen[s] <= 1'b1;
                end
              end
            end
          end
          r_kst <= K_ACK;
        end
        K_ACK: begin
          r_ack  <= 1'b1;
          r_recv <= r_recv + CSZ'(1);
          r_kst  <= K_HOLD;
        end
        K_HOLD: if (!i0_req) begin
          r_ack <= 1'b0;
          r_kst <= K_WAIT;
        end
        default: r_kst <= K_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ns_traffic_gen_chk.sv
// Bench for ns_traffic_gen_chk: loopback run, reset mid-handshake,
// and table-driven injection of sink error cases.
module tb_ns_traffic_gen_chk;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       loop = 1'b0;
  logic [7:0] o0_src, o0_dst, o0_dat;
  logic [3:0] o0_red;
  logic       o0_req, o0_ack, i0_ack;
  logic [7:0] t_src = '0, t_dst = '0, t_dat = '0;
  logic [3:0] t_red = '0;
  logic       t_req = 1'b0;
  logic [7:0] w_src, w_dst, w_dat;
  logic [3:0] w_red;
  logic       w_req;
  logic [1:0] err_red, err_seq;
  logic       err_rng, err_src, done;
  logic [7:0] fst_exp, fst_got;
  logic [15:0] sent, recv;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign w_src  = loop ? o0_src : t_src;
  assign w_dst  = loop ? o0_dst : t_dst;
  assign w_dat  = loop ? o0_dat : t_dat;
  assign w_red  = loop ? o0_red : t_red;
  assign w_req  = loop ? o0_req : t_req;
  assign o0_ack = loop ? i0_ack : 1'b0;

  ns_traffic_gen_chk #(
    .SRC_ID(0), .MIN_ADDR(1), .MAX_ADDR(3),
    .ASZ(8), .DSZ(8), .RSZ(4), .NUM_SRC(2),
    .CNT_MAX(15), .MSG_LIMIT(40), .CSZ(16)
  ) dut (
    .i_clk(clk), .reset(rst), .i_enable(en),
    .o0_src(o0_src), .o0_dst(o0_dst), .o0_dat(o0_dat),
    .o0_red(o0_red), .o0_req(o0_req), .o0_ack(o0_ack),
    .i0_src(w_src), .i0_dst(w_dst), .i0_dat(w_dat),
    .i0_red(w_red), .i0_req(w_req), .i0_ack(i0_ack),
    .o_err_red(err_red), .o_err_seq(err_seq),
    .o_err_rng(err_rng), .o_err_src(err_src),
    .o_fst_exp(fst_exp), .o_fst_got(fst_got),
    .o_sent_cnt(sent), .o_recv_cnt(recv), .o_done(done)
  );

  function automatic logic [3:0] red4(
    input logic [7:0] s, input logic [7:0] d, input logic [7:0] x
  );
    return s[3:0] ^ s[7:4] ^ d[3:0] ^ d[7:4] ^ x[3:0] ^ x[7:4];
  endfunction

  task automatic check(
    input string nm, input logic [31:0] got, input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic wait_req(input logic v);
    int n = 0;
    while (o0_req !== v && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (o0_req !== v) check("o0_req timeout", 32'(o0_req), 32'(v));
  endtask

  task automatic wait_ack(input logic v);
    int n = 0;
    while (i0_ack !== v && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (i0_ack !== v) check("i0_ack timeout", 32'(i0_ack), 32'(v));
  endtask

  task automatic send(
    input logic [7:0] s, input logic [7:0] x, input logic bad
  );
    @(negedge clk);
    t_src = s;
    t_dst = 8'h05;
    t_dat = x;
    t_red = red4(s, 8'h05, x) ^ {3'b000, bad};
    t_req = 1'b1;
    wait_ack(1'b1);
    t_req = 1'b0;
    wait_ack(1'b0);
    @(negedge clk);
  endtask

  task automatic check_quiet(input string nm);
    check({nm, " err_seq"}, 32'(err_seq), 32'd0);
    check({nm, " err_red"}, 32'(err_red), 32'd0);
    check({nm, " err_rng"}, 32'(err_rng), 32'd0);
    check({nm, " err_src"}, 32'(err_src), 32'd0);
  endtask

  typedef struct {
    logic [7:0] src;
    logic [7:0] dat;
    logic       bad;
    logic [1:0] seq;
    logic [1:0] red;
    logic       rng;
    logic       srcf;
    logic [7:0] fexp;
    logic [7:0] fgot;
  } vec_t;

  vec_t tv[9];

  initial begin
    tv[0] = '{8'd1, 8'd4,  1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 8'd0};
    tv[1] = '{8'd1, 8'd5,  1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 8'd0};
    tv[2] = '{8'd1, 8'd7,  1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 8'd6, 8'd7};
    tv[3] = '{8'd1, 8'd8,  1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 8'd6, 8'd7};
    tv[4] = '{8'd0, 8'd2,  1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 8'd6, 8'd7};
    tv[5] = '{8'd0, 8'd3,  1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 8'd6, 8'd7};
    tv[6] = '{8'd0, 8'd3,  1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 8'd6, 8'd7};
    tv[7] = '{8'd5, 8'd0,  1'b0, 2'b10, 2'b01, 1'b0, 1'b1, 8'd6, 8'd7};
    tv[8] = '{8'd1, 8'd20, 1'b0, 2'b10, 2'b01, 1'b1, 1'b1, 8'd6, 8'd7};

    // reset state
    repeat (3) @(negedge clk);
    check("rst o0_req", 32'(o0_req), 32'd0);
    check("rst i0_ack", 32'(i0_ack), 32'd0);
    check("rst o0_dst", 32'(o0_dst), 32'd1);
    check("rst o0_src", 32'(o0_src), 32'd0);
    check("rst o0_dat", 32'(o0_dat), 32'd0);
    check("rst o0_red", 32'(o0_red), 32'd0);
    check("rst sent", 32'(sent), 32'd0);
    check("rst recv", 32'(recv), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst fst_exp", 32'(fst_exp), 32'd0);
    check("rst fst_got", 32'(fst_got), 32'd0);
    check_quiet("rst");

    // loopback run of 40 messages
    loop = 1'b1;
    en   = 1'b1;
    rst  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      logic [7:0] ed, ea;
      ed = 8'(k % 16);
      ea = 8'(1 + k % 3);
      wait_req(1'b1);
      check($sformatf("lb dat[%0d]", k), 32'(o0_dat), 32'(ed));
      check($sformatf("lb dst[%0d]", k), 32'(o0_dst), 32'(ea));
      check($sformatf("lb red[%0d]", k), 32'(o0_red),
            32'(red4(8'h00, ea, ed)));
      wait_req(1'b0);
    end
    repeat (20) @(negedge clk);
    check("lb done", 32'(done), 32'd1);
    check("lb sent", 32'(sent), 32'd40);
    check("lb recv", 32'(recv), 32'd40);
    check("lb req idle", 32'(o0_req), 32'd0);
    check_quiet("lb");

    // reset in the middle of a handshake
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    begin
      int n = 0;
      while (!(o0_req === 1'b1 && i0_ack === 1'b1) && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("mid req&ack seen", 32'(o0_req & i0_ack), 32'd1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid o0_req", 32'(o0_req), 32'd0);
    check("mid i0_ack", 32'(i0_ack), 32'd0);
    check("mid sent", 32'(sent), 32'd0);
    check("mid recv", 32'(recv), 32'd0);
    check("mid dst", 32'(o0_dst), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_req(1'b1);
      check($sformatf("rs dat[%0d]", k), 32'(o0_dat), 32'(k));
      check($sformatf("rs dst[%0d]", k), 32'(o0_dst), 32'(1 + k % 3));
      wait_req(1'b0);
    end
    check("rs sent", 32'(sent), 32'd4);
    check("rs recv", 32'(recv), 32'd4);
    check_quiet("rs");

    // quiesce source, then inject messages from the bench
    en = 1'b0;
    repeat (20) @(negedge clk);
    loop = 1'b0;
    rst  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send(tv[i].src, tv[i].dat, tv[i].bad);
      check($sformatf("inj%0d err_seq", i), 32'(err_seq), 32'(tv[i].seq));
      check($sformatf("inj%0d err_red", i), 32'(err_red), 32'(tv[i].red));
      check($sformatf("inj%0d err_rng", i), 32'(err_rng), 32'(tv[i].rng));
      check($sformatf("inj%0d err_src", i), 32'(err_src), 32'(tv[i].srcf));
      check($sformatf("inj%0d fst_exp", i), 32'(fst_exp), 32'(tv[i].fexp));
      check($sformatf("inj%0d fst_got", i), 32'(fst_got), 32'(tv[i].fgot));
      check($sformatf("inj%0d recv", i), 32'(recv), 32'(i + 1));
    end
    check("inj sent idle", 32'(sent), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
